// File: rtl/c17_bist_pkg.sv
// Shared types and default constants for the c17 BIST response compactor.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [15:0] DEF_POLY    = 16'h1021;
  localparam logic [15:0] DEF_SEED    = 16'h0000;
  // Exhaustive pattern count for the 5-input c17.
  localparam int          DEF_NUM_PAT = 32;

endpackage

// File: rtl/c17_resp_misr_misr_reg.sv
// Parameterised multiple-input signature register with synchronous load,
// enable and a 2-bit parallel data input folded into the two low bits.
module misr_reg
  import c17_bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       din,
  output logic [SIG_W-1:0] sig_q,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] fb_s;

  // Next-state: load wins over a shift-and-fold step.
  always_comb begin
    fb_s  = sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ fb_s ^ SIG_W'(din);
    end else begin
      sig_d = sig_q;
    end
  end

  assign sig_next = sig_d;

  // Signature register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

endmodule

// File: rtl/c17_resp_misr.sv
// Response compactor for c17 BIST: control FSM, pattern counter and MISR.
// Optional golden-signature comparator enabled by C17_MISR_GOLDEN_CMP_EN.
module c17_resp_misr
  import c17_bist_pkg::*;
#(
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED    = DEF_SEED,
  parameter int               NUM_PAT = DEF_NUM_PAT,
  parameter int               PAT_W   = 6,
  parameter logic [SIG_W-1:0] GOLDEN  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic             N22q,
  input  logic             N23q2,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
`ifdef C17_MISR_GOLDEN_CMP_EN
  output logic             pass,
`endif
  output logic [PAT_W-1:0] pat_cnt
);

  localparam logic [PAT_W-1:0] LAST_CNT = PAT_W'(NUM_PAT - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_s;
  logic             en_s;
  logic [SIG_W-1:0] sig_q_s;
  logic [SIG_W-1:0] sig_next_s;

  misr_reg #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .en       (en_s),
    .din      ({N23q2, N22q}),
    .sig_q    (sig_q_s),
    .sig_next (sig_next_s)
  );

  // FSM and counter next-state; a restart takes priority over any response.
  always_comb begin
    state_d   = state_q;
    pat_cnt_d = pat_cnt_q;
    load_s    = 1'b0;
    en_s      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CAPTURE;
          pat_cnt_d = {PAT_W{1'b0}};
          load_s    = 1'b1;
        end else begin
          state_d   = state_q;
        end
      end
      CAPTURE: begin
        if (resp_valid) begin
          en_s      = 1'b1;
          pat_cnt_d = pat_cnt_q + PAT_W'(1);
          state_d   = (pat_cnt_q == LAST_CNT) ? DONE : CAPTURE;
        end else begin
          state_d   = CAPTURE;
        end
      end
      default: begin
        state_d   = IDLE;
        pat_cnt_d = {PAT_W{1'b0}};
      end
    endcase
    busy_d = (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  // Control registers; outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_cnt_q <= {PAT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_cnt_q <= pat_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef C17_MISR_GOLDEN_CMP_EN
  logic pass_q, pass_d;

  // Compare the signature that will be held in DONE, so pass lands with done.
  always_comb begin
    if (state_d == DONE) begin
      pass_d = (sig_next_s == GOLDEN);
    end else begin
      pass_d = 1'b0;
    end
  end

  // Registered comparator result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign pass = pass_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q_s;
  assign pat_cnt   = pat_cnt_q;

endmodule

// File: doc/c17_resp_misr.md
# c17_resp_misr

Response compactor for the c17 benchmark under built-in self-test. It consumes the registered c17 outputs N22q and N23q2 for a programmed number of test patterns. It folds them into a multiple-input signature register (MISR) and reports a final signature for off-line or on-chip comparison. It sits directly downstream of c17 and shares the c17 clock.

## Interface
Parameters:
- SIG_W, 16: signature width; minimum 2.
- POLY, 16'h1021: feedback polynomial mask, SIG_W bits.
- SEED, 16'h0000: signature value loaded on reset and on each start.
- NUM_PAT, 32: responses per run; range 1 to 2^PAT_W−1.
- PAT_W, 6: pattern counter width.
- GOLDEN, 16'h0000: expected signature; used only with the macro.

Ports:
- clk, input, 1: rising-edge clock, same clock as c17.
- rst, input, 1: reset, synchronous and active-high.
- start, input, 1: single-cycle pulse; begins a run.
- resp_valid, input, 1: N22q/N23q2 hold a valid response this cycle.
- N22q, input, 1: c17 output 22, registered.
- N23q2, input, 1: c17 output 23, registered.
- busy, output, 1: high in CAPTURE.
- done, output, 1: high in DONE.
- signature, output, SIG_W: current MISR contents.
- pat_cnt, output, PAT_W: number of responses captured in the current run.
- pass, output, 1: present only with the macro.

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- Reset, rst=1 at an edge, gives: state=IDLE, signature=SEED, pat_cnt=0, busy=0, done=0, pass=0. rst overrides every other input.
- IDLE → CAPTURE on start. The same edge loads signature=SEED and pat_cnt=0.
- CAPTURE step: on each edge with resp_valid=1, the MISR updates:
  - sig_next = (sig << 1) ^ (sig[SIG_W−1] ? POLY : 0) ^ {0…, N23q2, N22q}.
  - N22q enters bit 0 and N23q2 enters bit 1.
  - pat_cnt increments.
- CAPTURE with resp_valid=0: signature and pat_cnt hold.
- CAPTURE → DONE on the edge that captures response number NUM_PAT. That capture is applied on the same edge.
- DONE: signature and pat_cnt are frozen; resp_valid is ignored.
- DONE → CAPTURE on start. Reload SEED, clear pat_cnt, clear done.
- start in CAPTURE is ignored; the run continues.
- resp_valid in IDLE or DONE is ignored.
- start and resp_valid together in IDLE or DONE: only the restart takes effect; the response is not captured.
- All arithmetic is modulo 2^SIG_W. pat_cnt never wraps, because the FSM leaves CAPTURE at NUM_PAT.

## Timing
- Outputs are registered; no combinational input-to-output paths.
- Latency: a response sampled at edge k is visible on signature after edge k.
- done rises after the edge that captures response NUM_PAT.
- Minimum run length is NUM_PAT cycles, with resp_valid held high continuously.
- The c17 output register adds one cycle. The upstream pattern source must delay resp_valid one cycle relative to pattern apply.
- Reset asserted mid-run aborts the run with no partial result retained.

## Configuration
- C17_MISR_GOLDEN_CMP_EN defined:
  - Adds the pass output.
  - pass is registered and equals (signature == GOLDEN) while in DONE.
  - pass is 0 in IDLE and CAPTURE, and 0 on reset.
  - pass updates on the edge that enters DONE.
- Macro undefined: there is no pass port and no comparator logic.

## Structure
- Package c17_bist_pkg holds:
  - the state enum (IDLE, CAPTURE, DONE);
  - the default POLY and SEED constants;
  - the default NUM_PAT = 32, the c17 exhaustive count.
- One sub-module, misr_reg: a parameterised SIG_W MISR with load, enable and 2-bit data input.
- The FSM, counter and comparator stay in the top module.

## Test plan
- Reset values: rst=1 for 2 cycles → signature=0000, pat_cnt=0, busy=0, done=0, pass=0.
- Basic update: NUM_PAT=2, start, then two valid responses with N22q=1, N23q2=1 → signature 0003, then 0005; done=1 after the 2nd edge; pat_cnt=2.
- Feedback path: SEED=8000, NUM_PAT=1, one response 00 → signature=1021, done=1.
- Exhaustive run: 32 valid responses, all 00, with resp_valid gaps inserted → signature=0000, pat_cnt=32; with the macro, pass=1. Repeat with one response 01 → pass=0.
- Input filtering: start mid-CAPTURE is ignored. resp_valid in DONE leaves signature unchanged. A second start in DONE reloads SEED and clears done.
- Abort: rst at pattern 10 → all outputs return to their reset values; a following start runs cleanly to NUM_PAT.
